// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the front-panel ALU sequencer and the ALU datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_RUN  = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } seq_state_t;

  // {C,Z,N,V}
  typedef logic [3:0] alu_flags_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

endpackage

// File: rtl/btn_pulse.sv
// Raw button level -> 2-FF synchronizer -> single-cycle pulse on each rising edge.
module btn_pulse (
  input  logic hz100,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-panel ALU sequencer: operand/opcode entry, start/done handshake, held result.
// Optional RUN timeout enabled by defining ALU_OP_SEQUENCER_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OPW        = 3,
  parameter int TMO_CYCLES = 200
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic [WIDTH-1:0] entry,
  input  logic [OPW-1:0]   op_sel,
  input  logic             btn_next,
  input  logic             btn_back,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  alu_flags_t       alu_flags,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             result_valid,
  output logic [2:0]       state,
  output logic             timeout_err
);

  seq_state_t state_q, state_d;
  logic next_p, back_p;
  logic ld_a, ld_b, ld_op, ld_res;
  logic done_ok, tmo_exp;

  btn_pulse u_next (.hz100(hz100), .reset(reset), .btn(btn_next), .pulse(next_p));
  btn_pulse u_back (.hz100(hz100), .reset(reset), .btn(btn_back), .pulse(back_p));

  // The launch cycle itself never accepts done, so the ALU gets at least one cycle.
  assign done_ok = (state_q == S_RUN) && !alu_start && alu_done;

`ifdef ALU_OP_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset)                 tmo_cnt <= '0;
    else if (state_q != S_RUN) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_exp = (state_q == S_RUN) && (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= (state_d == S_ERR);
  end
`else
  assign tmo_exp     = 1'b0;
  assign timeout_err = 1'b0;
  if (TMO_CYCLES < 1) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) state_q <= S_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    unique case (state_q)
      S_A:    if (next_p && !back_p) begin ld_a = 1'b1; state_d = S_B; end
      S_B:    if (back_p) state_d = S_A;
              else if (next_p) begin ld_b = 1'b1; state_d = S_OP; end
      S_OP:   if (back_p) state_d = S_B;
              else if (next_p) begin ld_op = 1'b1; state_d = S_RUN; end
      S_RUN:  if (done_ok) begin ld_res = 1'b1; state_d = S_SHOW; end
              else if (tmo_exp) state_d = S_ERR;
      S_SHOW: if (back_p) state_d = S_OP;
              else if (next_p) state_d = S_A;
      S_ERR:  if (next_p || back_p) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // Operand, opcode and result holding registers
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_start    <= 1'b0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
    end else begin
      alu_start <= ld_op;
      if (ld_a) alu_a <= entry;
      if (ld_b) alu_b <= entry;
      if (ld_op) begin
        alu_op       <= op_sel;
        result_valid <= 1'b0;
      end
      if (ld_res) begin
        result       <= alu_result;
        flags        <= alu_flags;
        result_valid <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer plus hand-written multi-cycle sequences.
module tb_alu_op_sequencer;

  logic       hz100, reset;
  logic [7:0] entry;
  logic [2:0] op_sel;
  logic       btn_next, btn_back;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_start, alu_done;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic [7:0] result;
  logic [3:0] flags;
  logic       result_valid;
  logic [2:0] state;
  logic       timeout_err;

  int passed = 0;
  int total  = 0;
  int start_cnt = 0;

  alu_op_sequencer #(.WIDTH(8), .OPW(3), .TMO_CYCLES(10)) dut (
    .hz100(hz100), .reset(reset), .entry(entry), .op_sel(op_sel),
    .btn_next(btn_next), .btn_back(btn_back),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .result(result), .flags(flags), .result_valid(result_valid),
    .state(state), .timeout_err(timeout_err)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  always @(negedge hz100) if (alu_start) start_cnt++;

  typedef struct {
    logic [7:0] entry;
    logic [2:0] op;
    logic       nx;
    logic       bk;
    logic [2:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op_e;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic press(input logic nx, input logic bk);
    @(negedge hz100);
    btn_next = nx;
    btn_back = bk;
    repeat (3) @(posedge hz100);
    @(negedge hz100);
    btn_next = 1'b0;
    btn_back = 1'b0;
    repeat (3) @(posedge hz100);
    @(negedge hz100);
  endtask

  task automatic reply(input logic [7:0] r, input logic [3:0] f);
    @(negedge hz100);
    alu_done   = 1'b1;
    alu_result = r;
    alu_flags  = f;
    @(negedge hz100);
    alu_done   = 1'b0;
    alu_result = 8'h00;
    alu_flags  = 4'h0;
    @(negedge hz100);
  endtask

  initial begin
    reset = 1'b1; entry = 8'h00; op_sel = 3'd0;
    btn_next = 1'b0; btn_back = 1'b0;
    alu_done = 1'b0; alu_result = 8'h00; alu_flags = 4'h0;

    //            entry  op    nx    bk    state  a      b      op
    tbl[0] = '{8'h12, 3'd0, 1'b1, 1'b0, 3'd1, 8'h12, 8'h00, 3'd0};
    tbl[1] = '{8'h34, 3'd0, 1'b1, 1'b0, 3'd2, 8'h12, 8'h34, 3'd0};
    tbl[2] = '{8'h34, 3'd3, 1'b0, 1'b1, 3'd1, 8'h12, 8'h34, 3'd0};
    tbl[3] = '{8'h55, 3'd3, 1'b0, 1'b1, 3'd0, 8'h12, 8'h34, 3'd0};
    tbl[4] = '{8'h12, 3'd3, 1'b1, 1'b0, 3'd1, 8'h12, 8'h34, 3'd0};
    tbl[5] = '{8'h34, 3'd3, 1'b1, 1'b0, 3'd2, 8'h12, 8'h34, 3'd0};
    tbl[6] = '{8'h34, 3'd3, 1'b1, 1'b0, 3'd3, 8'h12, 8'h34, 3'd3};

    repeat (2) @(negedge hz100);
    check("rst_state", state, 3'd0);
    check("rst_a", alu_a, 8'h00);
    check("rst_result", result, 8'h00);
    check("rst_valid", result_valid, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_start", alu_start, 1'b0);
    reset = 1'b0;
    @(negedge hz100);

    for (int i = 0; i < 7; i++) begin
      entry  = tbl[i].entry;
      op_sel = tbl[i].op;
      press(tbl[i].nx, tbl[i].bk);
      check($sformatf("v%0d_state", i), state, tbl[i].st);
      check($sformatf("v%0d_a", i), alu_a, tbl[i].a);
      check($sformatf("v%0d_b", i), alu_b, tbl[i].b);
      check($sformatf("v%0d_op", i), alu_op, tbl[i].op_e);
    end
    check("run_valid_clr", result_valid, 1'b0);

    // ALU answers after a few cycles in RUN
    repeat (3) @(negedge hz100);
    reply(8'h46, 4'h0);
    check("flow_state", state, 3'd4);
    check("flow_result", result, 8'h46);
    check("flow_flags", flags, 4'h0);
    check("flow_valid", result_valid, 1'b1);
    check("flow_starts", start_cnt, 1);

    // Back from SHOW to rerun with a new opcode
    press(1'b0, 1'b1);
    check("show_back_state", state, 3'd2);
    check("show_back_valid", result_valid, 1'b1);
    op_sel = 3'd5;
    press(1'b1, 1'b0);
    check("rerun_state", state, 3'd3);
    check("rerun_valid", result_valid, 1'b0);
    check("rerun_op", alu_op, 3'd5);
    check("rerun_starts", start_cnt, 2);
    reply(8'h99, 4'hA);
    check("rerun_result", result, 8'h99);
    check("rerun_flags", flags, 4'hA);
    check("rerun_valid2", result_valid, 1'b1);

    press(1'b1, 1'b0);
    check("show_next_state", state, 3'd0);
    check("show_next_a", alu_a, 8'h12);
    check("show_next_result", result, 8'h99);

    // Stray done outside RUN
    reply(8'hEE, 4'hF);
    check("stray_state", state, 3'd0);
    check("stray_result", result, 8'h99);

    // Held button: one transition, one latch
    @(negedge hz100);
    entry = 8'h77;
    btn_next = 1'b1;
    repeat (5) @(negedge hz100);
    entry = 8'h88;
    repeat (45) @(negedge hz100);
    btn_next = 1'b0;
    repeat (4) @(negedge hz100);
    check("held_state", state, 3'd1);
    check("held_a", alu_a, 8'h77);

    // Simultaneous next+back in S_B
    entry = 8'h66;
    press(1'b1, 1'b1);
    check("both_state", state, 3'd0);
    check("both_b", alu_b, 8'h34);

    // RUN with no answer
    entry = 8'h01; press(1'b1, 1'b0);
    entry = 8'h02; press(1'b1, 1'b0);
    op_sel = 3'd1; press(1'b1, 1'b0);
    check("tmo_run", state, 3'd3);
    repeat (15) @(negedge hz100);
`ifdef ALU_OP_SEQUENCER_TIMEOUT_EN
    check("tmo_state", state, 3'd5);
    check("tmo_err", timeout_err, 1'b1);
    check("tmo_valid", result_valid, 1'b0);
    press(1'b1, 1'b0);
    check("tmo_clr_state", state, 3'd0);
    check("tmo_clr_err", timeout_err, 1'b0);
`else
    check("wait_state", state, 3'd3);
    check("wait_err", timeout_err, 1'b0);
    reply(8'h03, 4'h4);
    check("wait_done_state", state, 3'd4);
    check("wait_done_result", result, 8'h03);
    press(1'b1, 1'b0);
    check("wait_next_state", state, 3'd0);
`endif

    // Reset in the middle of RUN, then a late done
    entry = 8'h21; press(1'b1, 1'b0);
    entry = 8'h22; press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("rrun_state", state, 3'd3);
    @(negedge hz100);
    reset = 1'b1;
    @(negedge hz100);
    reset = 1'b0;
    reply(8'h55, 4'hF);
    check("rrun_after_state", state, 3'd0);
    check("rrun_after_result", result, 8'h00);
    check("rrun_after_valid", result_valid, 1'b0);
    check("rrun_after_a", alu_a, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
